modbus_rtu_rx_framer: RTL



---
 rtl/modbus_rtu_rx_framer_if.sv | 34 +++
 rtl/modbus_rtu_rx_framer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/modbus_rtu_rx_framer_if.sv
// Signal bundle between the Modbus RTU receive framer and its UART, CRC16 engine, frame buffer and protocol layer.
// master = framer side, slave = environment side.
interface modbus_rtu_rx_framer_if #(
    parameter int MAX_LEN = 256
);
    logic [7:0]                   rx_data;
    logic                         rx_valid;
    logic                         rx_err;
    logic [7:0]                   crc_data;
    logic                         crc_en;
    logic                         crc_rst;
    logic [15:0]                  crc_in;
    logic [7:0]                   buf_wdata;
    logic [$clog2(MAX_LEN)-1:0]   buf_waddr;
    logic                         buf_we;
    logic                         frame_done;
    logic                         frame_ok;
    logic [$clog2(MAX_LEN+1)-1:0] frame_len;
    logic [4:0]                   err;

    modport master (
        input  rx_data, rx_valid, rx_err, crc_in,
        output crc_data, crc_en, crc_rst,
        output buf_wdata, buf_waddr, buf_we,
        output frame_done, frame_ok, frame_len, err
    );

    modport slave (
        output rx_data, rx_valid, rx_err, crc_in,
        input  crc_data, crc_en, crc_rst,
        input  buf_wdata, buf_waddr, buf_we,
        input  frame_done, frame_ok, frame_len, err
    );
endinterface

// File: rtl/modbus_rtu_rx_framer.sv
// Modbus RTU receive framer: silence-delimited framing, buffer writes, CRC16 feed and per-frame status.
// Optional station-address filter enabled by defining MODBUS_RX_ADDR_FILTER_EN.
//
// state  | meaning
// WAIT35 | after reset, ignore bytes until t3.5 of silence
// IDLE   | line quiet, CRC held in reset, next byte starts a frame
// RECV   | collecting frame bytes
// CHECK  | one cycle: validate CRC/length, report status
// DROP   | frame addressed elsewhere, discard until t3.5 silence (filter build only)
module modbus_rtu_rx_framer #(
    parameter int T15_CYCLES = 750,
    parameter int T35_CYCLES = 1750,
    parameter int MAX_LEN    = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            my_addr,
    modbus_rtu_rx_framer_if.master bus
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(T35_CYCLES + 1);
    localparam logic [CW-1:0] T35     = CW'(T35_CYCLES);
    localparam logic [CW-1:0] T15     = CW'(T15_CYCLES);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_SAT = LW'(MAX_LEN + 1);

    typedef enum logic [2:0] {S_WAIT35, S_IDLE, S_RECV, S_CHECK, S_DROP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   count_q, count_d;
    logic [7:0]      d0_q, d0_d, d1_q, d1_d;
    logic [4:0]      err_acc_q, err_acc_d;
    logic [4:0]      err_fin;
    logic            crc_en_q, crc_en_d;
    logic [7:0]      crc_data_q, crc_data_d;
    logic            crc_rst_q, crc_rst_d;
    logic            buf_we_q, buf_we_d;
    logic [AW-1:0]   buf_waddr_q, buf_waddr_d;
    logic [7:0]      buf_wdata_q, buf_wdata_d;
    logic            frame_done_q, frame_done_d;
    logic            frame_ok_q, frame_ok_d;
    logic [LW-1:0]   frame_len_q, frame_len_d;
    logic [4:0]      err_q, err_d;
    logic            accept;

`ifdef MODBUS_RX_ADDR_FILTER_EN
    assign accept = (bus.rx_data == my_addr) || (bus.rx_data == 8'h00);
`else
    logic unused_my_addr;
    assign unused_my_addr = ^my_addr;
    assign accept         = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = bus.rx_valid ? '0 : ((cnt_q == T35) ? cnt_q : cnt_q + CW'(1));
        count_d      = count_q;
        d0_d         = d0_q;
        d1_d         = d1_q;
        err_acc_d    = err_acc_q;
        err_fin      = err_acc_q;
        crc_en_d     = 1'b0;
        crc_data_d   = crc_data_q;
        buf_we_d     = 1'b0;
        buf_waddr_d  = buf_waddr_q;
        buf_wdata_d  = buf_wdata_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        frame_len_d  = frame_len_q;
        err_d        = err_q;

        case (state_q)
            S_WAIT35: begin
                if (cnt_q == T35) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if (accept) begin
                        state_d     = S_RECV;
                        count_d     = LW'(1);
                        d1_d        = d0_q;
                        d0_d        = bus.rx_data;
                        err_acc_d   = {1'b0, bus.rx_err, 3'b000};
                        buf_we_d    = 1'b1;
                        buf_waddr_d = '0;
                        buf_wdata_d = bus.rx_data;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_RECV: begin
                if (bus.rx_valid) begin
                    if (cnt_q > T15) err_acc_d[1] = 1'b1;
                    d1_d = d0_q;
                    d0_d = bus.rx_data;
                    // CRC runs two bytes behind so the trailing CRC field never enters it
                    if (count_q >= LW'(2)) begin
                        crc_en_d   = 1'b1;
                        crc_data_d = d1_q;
                    end
                    if (count_q < LEN_MAX) begin
                        buf_we_d    = 1'b1;
                        buf_waddr_d = count_q[AW-1:0];
                        buf_wdata_d = bus.rx_data;
                    end else begin
                        err_acc_d[2] = 1'b1;
                    end
                    if (count_q != LEN_SAT) count_d = count_q + LW'(1);
                end else if (cnt_q == T35) begin
                    state_d = S_CHECK;
                end
                if (bus.rx_err) err_acc_d[3] = 1'b1;
            end
            S_CHECK: begin
                err_fin[4]   = (count_q < LW'(4));
                err_fin[0]   = (count_q >= LW'(4)) && (bus.crc_in != {d0_q, d1_q});
                frame_done_d = 1'b1;
                frame_ok_d   = (err_fin == 5'd0);
                frame_len_d  = count_q;
                err_d        = err_fin;
                state_d      = S_IDLE;
            end
            S_DROP: begin
                if (!bus.rx_valid && cnt_q == T35) state_d = S_IDLE;
            end
            default: state_d = S_WAIT35;
        endcase

        crc_rst_d = !(state_d == S_RECV || state_d == S_CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_WAIT35;
            cnt_q        <= '0;
            count_q      <= '0;
            d0_q         <= '0;
            d1_q         <= '0;
            err_acc_q    <= '0;
            crc_en_q     <= 1'b0;
            crc_data_q   <= '0;
            crc_rst_q    <= 1'b1;
            buf_we_q     <= 1'b0;
            buf_waddr_q  <= '0;
            buf_wdata_q  <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_len_q  <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            count_q      <= count_d;
            d0_q         <= d0_d;
            d1_q         <= d1_d;
            err_acc_q    <= err_acc_d;
            crc_en_q     <= crc_en_d;
            crc_data_q   <= crc_data_d;
            crc_rst_q    <= crc_rst_d;
            buf_we_q     <= buf_we_d;
            buf_waddr_q  <= buf_waddr_d;
            buf_wdata_q  <= buf_wdata_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            frame_len_q  <= frame_len_d;
            err_q        <= err_d;
        end
    end

    assign bus.crc_en     = crc_en_q;
    assign bus.crc_data   = crc_data_q;
    assign bus.crc_rst    = crc_rst_q;
    assign bus.buf_we     = buf_we_q;
    assign bus.buf_waddr  = buf_waddr_q;
    assign bus.buf_wdata  = buf_wdata_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_ok   = frame_ok_q;
    assign bus.frame_len  = frame_len_q;
    assign bus.err        = err_q;
endmodule
